// File: rtl/sram_async_if_p.sv
// Wishbone-style classic slave bridging a DBW-bit bus to an external asynchronous SRAM.
// Each bus access is split into MW-bit memory beats spanning the first..last selected lanes.
module sram_async_if_p #(
  parameter int DBW      = 32,
  parameter int MW       = 8,
  parameter int AW       = 19,
  parameter int RD_WAIT  = 2,
  parameter int WR_SETUP = 1,
  parameter int WR_PULSE = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cs_i,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  output logic                 ack_o,
  input  logic                 we_i,
  input  logic [DBW/8-1:0]     sel_i,
  input  logic [31:0]          adr_i,
  input  logic [DBW-1:0]       dat_i,
  output logic [DBW-1:0]       dat_o,
  output logic                 RamCEn,
  output logic                 RamWEn,
  output logic                 RamOEn,
  output logic [MW/8-1:0]      RamBEn,
  output logic [AW-1:0]        MemAdr,
  output logic [MW-1:0]        MemDB_o,
  input  logic [MW-1:0]        MemDB_i,
  output logic [MW-1:0]        MemT
);

  localparam int NB  = DBW / MW;        // memory beats per bus word
  localparam int BW  = $clog2(NB);      // beat index width
  localparam int LB  = MW / 8;          // byte lanes per beat
  localparam int OFF = $clog2(DBW / 8); // byte offset bits within a bus word
  localparam int HW  = 32 - OFF;        // bus word address width

  typedef logic [BW-1:0] beat_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RWAIT,
    S_RCAP,
    S_WSET,
    S_WPUL,
    S_WHLD,
    S_DONE,
    S_NACK
  } state_t;

  state_t             state_q, state_d;
  beat_t              beat_q, beat_d;
  beat_t              last_q, last_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [DBW/8-1:0]   sel_q, sel_d;
  logic [DBW-1:0]     dat_q, dat_d;
  logic               we_q, we_d;
  logic [HW-1:0]      hi_q, hi_d;
  logic [DBW-1:0]     rdat_q, rdat_d;
  logic               ack_q, ack_d;
  logic               cen_q, cen_d;
  logic               oen_q, oen_d;
  logic               wen_q, wen_d;
  logic [LB-1:0]      ben_q, ben_d;
  logic [AW-1:0]      adr_q, adr_d;
  logic [MW-1:0]      dbo_q, dbo_d;
  logic               t_q, t_d;

  logic               csi;
  beat_t              first_b, last_b, beat_nx;
  logic [LB-1:0]      cur_lanes, nxt_lanes;
  logic [MW-1:0]      rmask;
  logic               finish;
  logic               unused_adr;

  function automatic logic [LB-1:0] lane_of(input logic [DBW/8-1:0] s, input beat_t b);
    return s[b*LB +: LB];
  endfunction

  function automatic logic [MW-1:0] word_of(input logic [DBW-1:0] d, input beat_t b);
    return d[b*MW +: MW];
  endfunction

  function automatic logic [AW-1:0] mk_adr(input logic [HW-1:0] hi, input beat_t b);
    return AW'({hi, b});
  endfunction

  assign csi        = cs_i & cyc_i & stb_i;
  assign unused_adr = ^adr_i[OFF-1:0];
  assign beat_nx    = beat_t'(beat_q + 1'b1);
  assign cur_lanes  = lane_of(sel_q, beat_q);
  assign nxt_lanes  = lane_of(sel_q, beat_nx);

  // Lowest and highest beat holding at least one selected byte lane.
  always_comb begin
    first_b = '0;
    last_b  = '0;
    for (int b = NB - 1; b >= 0; b--) begin
      if (|sel_i[b*LB +: LB]) first_b = beat_t'(b);
    end
    for (int b = 0; b < NB; b++) begin
      if (|sel_i[b*LB +: LB]) last_b = beat_t'(b);
    end
  end

  always_comb begin
    rmask = '0;
    for (int i = 0; i < LB; i++) begin
      rmask[i*8 +: 8] = {8{cur_lanes[i]}};
    end
  end

  // NOTE: every variable gets its hold value before the case statement, so no
  // branch can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    we_d    = we_q;
    hi_d    = hi_q;
    rdat_d  = rdat_q;
    ack_d   = ack_q;
    cen_d   = cen_q;
    oen_d   = oen_q;
    wen_d   = wen_q;
    ben_d   = ben_q;
    adr_d   = adr_q;
    dbo_d   = dbo_q;
    t_d     = t_q;
    finish  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (csi) begin
          we_d   = we_i;
          rdat_d = '0;
          if (sel_i == '0) begin
            state_d = S_DONE;
          end else begin
            sel_d  = sel_i;
            dat_d  = dat_i;
            hi_d   = adr_i[31:OFF];
            beat_d = first_b;
            last_d = last_b;
            adr_d  = mk_adr(adr_i[31:OFF], first_b);
            ben_d  = ~lane_of(sel_i, first_b);
            cen_d  = 1'b0;
            if (we_i) begin
              t_d     = 1'b0;
              dbo_d   = word_of(dat_i, first_b);
              cnt_d   = 4'(WR_SETUP);
              state_d = S_WSET;
            end else begin
              oen_d   = 1'b0;
              cnt_d   = 4'(RD_WAIT);
              state_d = S_RWAIT;
            end
          end
        end
      end

      S_RWAIT: begin
        if (cnt_q == 4'd1) state_d = S_RCAP;
        else               cnt_d   = cnt_q - 4'd1;
      end

      S_RCAP: begin
        rdat_d[beat_q*MW +: MW] = MemDB_i & rmask;
        if (beat_q == last_q) begin
          finish = 1'b1;
        end else begin
          beat_d  = beat_nx;
          adr_d   = mk_adr(hi_q, beat_nx);
          ben_d   = ~nxt_lanes;
          cnt_d   = 4'(RD_WAIT);
          state_d = S_RWAIT;
        end
      end

      S_WSET: begin
        if (cnt_q == 4'd1) begin
          // A beat with no selected lanes still spends the pulse time, without strobing.
          wen_d   = ~|cur_lanes;
          cnt_d   = 4'(WR_PULSE);
          state_d = S_WPUL;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_WPUL: begin
        if (cnt_q == 4'd1) begin
          wen_d   = 1'b1;
          state_d = S_WHLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_WHLD: begin
        if (beat_q == last_q) begin
          finish = 1'b1;
        end else begin
          beat_d  = beat_nx;
          adr_d   = mk_adr(hi_q, beat_nx);
          dbo_d   = word_of(dat_q, beat_nx);
          ben_d   = ~nxt_lanes;
          cnt_d   = 4'(WR_SETUP);
          state_d = S_WSET;
        end
      end

      S_DONE: begin
        ack_d   = 1'b1;
        state_d = S_NACK;
      end

      S_NACK: begin
        if (!csi) begin
          ack_d   = 1'b0;
          rdat_d  = '0;
          adr_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Release the RAM pins on the edge that enters DONE.
    if (finish) begin
      cen_d   = 1'b1;
      oen_d   = 1'b1;
      wen_d   = 1'b1;
      t_d     = 1'b1;
      ben_d   = '1;
      dbo_d   = '0;
      state_d = S_DONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      hi_q    <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      cen_q   <= 1'b1;
      oen_q   <= 1'b1;
      wen_q   <= 1'b1;
      ben_q   <= '1;
      adr_q   <= '0;
      dbo_q   <= '0;
      t_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      hi_q    <= hi_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      cen_q   <= cen_d;
      oen_q   <= oen_d;
      wen_q   <= wen_d;
      ben_q   <= ben_d;
      adr_q   <= adr_d;
      dbo_q   <= dbo_d;
      t_q     <= t_d;
    end
  end

  assign ack_o   = ack_q & csi;
  assign dat_o   = (ack_o && !we_q) ? rdat_q : '0;
  assign RamCEn  = cen_q;
  assign RamOEn  = oen_q;
  assign RamWEn  = wen_q;
  // A byte-wide part has no byte enables; the pins are tied active.
  assign RamBEn  = (MW == 8) ? '0 : ben_q;
  assign MemAdr  = adr_q;
  assign MemDB_o = dbo_q;
  assign MemT    = {MW{t_q}};

endmodule
